// File: rtl/ysyx_25010008_mem_arb.sv
// ysyx_25010008_mem_arb
// Two-requester (IFU, LSU) arbiter in front of a single memory port.
// Only one memory transaction is outstanding at a time:
//   IDLE -> ISSUE (request held on mem_*) -> WAIT (response) -> IDLE.
// Build option: define ARB_RR_EN to break IFU/LSU ties round-robin
// (the requester not granted last wins). Without it, LSU always wins a tie.
module ysyx_25010008_mem_arb (
  input  logic        clk,
  input  logic        rst_n,
  // instruction fetch requester
  input  logic        ifu_req_valid,
  output logic        ifu_req_ready,
  input  logic [31:0] ifu_addr,
  output logic        ifu_resp_valid,
  output logic [31:0] ifu_rdata,
  // load/store requester
  input  logic        lsu_req_valid,
  output logic        lsu_req_ready,
  input  logic [31:0] lsu_addr,
  input  logic        lsu_wen,
  input  logic [31:0] lsu_wdata,
  input  logic [3:0]  lsu_wmask,
  output logic        lsu_resp_valid,
  output logic [31:0] lsu_rdata,
  // memory side
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_addr,
  output logic        mem_wen,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_rdata,
  // status
  output logic        busy,
  output logic        owner
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_e;

  state_e      state_r;
  state_e      state_next_s;
  logic        grant_lsu_s;
  logic        accept_s;
  logic        resp_done_s;

  logic [31:0] addr_r;
  logic        wen_r;
  logic [31:0] wdata_r;
  logic [3:0]  wmask_r;
  logic        owner_r;
  logic        ifu_resp_valid_r;
  logic        lsu_resp_valid_r;
  logic [31:0] ifu_rdata_r;
  logic [31:0] lsu_rdata_r;

`ifdef ARB_RR_EN
  // 1 when the LSU received the most recent grant; reset means "IFU last"
  logic last_lsu_r;

  // Winner selection: on a tie, grant whichever requester was not granted last
  always_comb begin
    if (lsu_req_valid && ifu_req_valid) begin
      grant_lsu_s = ~last_lsu_r;
    end else begin
      grant_lsu_s = lsu_req_valid;
    end
  end

  // Track the last grantee on every accepted request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_lsu_r <= 1'b0;
    end else if (accept_s) begin
      last_lsu_r <= grant_lsu_s;
    end else begin
      last_lsu_r <= last_lsu_r;
    end
  end
`else
  // Fixed priority: LSU wins whenever it is requesting
  assign grant_lsu_s = lsu_req_valid;
`endif

  assign accept_s    = (state_r == IDLE) && (ifu_req_valid || lsu_req_valid);
  assign resp_done_s = (state_r == WAIT) && mem_resp_valid;

  // Ready depends only on state and requester inputs, never on mem_* inputs
  assign ifu_req_ready = (state_r == IDLE) && ifu_req_valid && !grant_lsu_s;
  assign lsu_req_ready = (state_r == IDLE) && grant_lsu_s;

  assign mem_req_valid  = (state_r == ISSUE);
  assign mem_addr       = addr_r;
  assign mem_wen        = wen_r;
  assign mem_wdata      = wdata_r;
  assign mem_wmask      = wmask_r;
  assign busy           = (state_r != IDLE);
  assign owner          = owner_r;
  assign ifu_resp_valid = ifu_resp_valid_r;
  assign lsu_resp_valid = lsu_resp_valid_r;
  assign ifu_rdata      = ifu_rdata_r;
  assign lsu_rdata      = lsu_rdata_r;

  // Next-state logic for the single-outstanding transaction sequence
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_next_s = ISSUE;
        end else begin
          state_next_s = IDLE;
        end
      end
      ISSUE: begin
        if (mem_req_ready) begin
          state_next_s = WAIT;
        end else begin
          state_next_s = ISSUE;
        end
      end
      WAIT: begin
        if (mem_resp_valid) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = WAIT;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Capture the winning request so mem_* stays stable while the requester moves on
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_r  <= 32'd0;
      wen_r   <= 1'b0;
      wdata_r <= 32'd0;
      wmask_r <= 4'd0;
      owner_r <= 1'b0;
    end else if (accept_s) begin
      addr_r  <= grant_lsu_s ? lsu_addr : ifu_addr;
      wen_r   <= grant_lsu_s & lsu_wen;
      wdata_r <= grant_lsu_s ? lsu_wdata : 32'd0;
      wmask_r <= grant_lsu_s ? lsu_wmask : 4'd0;
      owner_r <= grant_lsu_s;
    end else begin
      addr_r  <= addr_r;
      wen_r   <= wen_r;
      wdata_r <= wdata_r;
      wmask_r <= wmask_r;
      owner_r <= owner_r;
    end
  end

  // Route the memory response to the owner: one-cycle valid pulse, data held until next response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ifu_resp_valid_r <= 1'b0;
      lsu_resp_valid_r <= 1'b0;
      ifu_rdata_r      <= 32'd0;
      lsu_rdata_r      <= 32'd0;
    end else begin
      ifu_resp_valid_r <= resp_done_s && !owner_r;
      lsu_resp_valid_r <= resp_done_s && owner_r;
      if (resp_done_s && !owner_r) begin
        ifu_rdata_r <= mem_rdata;
      end else begin
        ifu_rdata_r <= ifu_rdata_r;
      end
      if (resp_done_s && owner_r) begin
        lsu_rdata_r <= mem_rdata;
      end else begin
        lsu_rdata_r <= lsu_rdata_r;
      end
    end
  end

endmodule

// File: tb/tb_ysyx_25010008_mem_arb.sv
// Testbench for ysyx_25010008_mem_arb: directed scenarios followed by randomized
// transactions, checked against a transaction-level model (who wins, what the
// memory should see, which requester gets which data).
module tb_ysyx_25010008_mem_arb;

  logic        clk;
  logic        rst_n;
  logic        ifu_req_valid;
  logic        ifu_req_ready;
  logic [31:0] ifu_addr;
  logic        ifu_resp_valid;
  logic [31:0] ifu_rdata;
  logic        lsu_req_valid;
  logic        lsu_req_ready;
  logic [31:0] lsu_addr;
  logic        lsu_wen;
  logic [31:0] lsu_wdata;
  logic [3:0]  lsu_wmask;
  logic        lsu_resp_valid;
  logic [31:0] lsu_rdata;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_addr;
  logic        mem_wen;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_resp_valid;
  logic [31:0] mem_rdata;
  logic        busy;
  logic        owner;

  int n_asserts;
  int n_fails;

  // reference model state
  logic        m_last_lsu;   // 1: LSU was granted last
  logic        m_owner;
  logic [31:0] m_ifu_rdata;
  logic [31:0] m_lsu_rdata;

  ysyx_25010008_mem_arb dut (
    .clk(clk), .rst_n(rst_n),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
    .ifu_resp_valid(ifu_resp_valid), .ifu_rdata(ifu_rdata),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
    .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
    .lsu_resp_valid(lsu_resp_valid), .lsu_rdata(lsu_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata),
    .busy(busy), .owner(owner)
  );

  // free-running clock, 10 time units per cycle
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_last_lsu  = 1'b0;
    m_owner     = 1'b0;
    m_ifu_rdata = 32'd0;
    m_lsu_rdata = 32'd0;
  endtask

  // One complete transaction starting in IDLE. Ends at the cycle where the
  // response pulse is visible (state back in IDLE), so calls can run back-to-back.
  task automatic txn(input logic iv, input logic lv, input logic [31:0] ia,
                     input logic [31:0] la, input logic w, input logic [31:0] wd,
                     input logic [3:0] wm, input int rdly, input int pdly,
                     input logic [31:0] rd);
    logic        exp_lsu;
    logic [31:0] ea;
    logic        ew;
    logic [31:0] ewd;
    logic [3:0]  ewm;
    ifu_req_valid  = iv;
    ifu_addr       = ia;
    lsu_req_valid  = lv;
    lsu_addr       = la;
    lsu_wen        = w;
    lsu_wdata      = wd;
    lsu_wmask      = wm;
    mem_req_ready  = 1'($urandom);
    mem_resp_valid = 1'b0;
    #1;
    if (iv && lv) begin
`ifdef ARB_RR_EN
      exp_lsu = !m_last_lsu;
`else
      exp_lsu = 1'b1;
`endif
    end else begin
      exp_lsu = lv;
    end
    chk("idle_ifu_ready", {31'd0, ifu_req_ready}, {31'd0, iv && !exp_lsu});
    chk("idle_lsu_ready", {31'd0, lsu_req_ready}, {31'd0, lv && exp_lsu});
    chk("idle_busy", {31'd0, busy}, 32'd0);
    if (!iv && !lv) begin
      mem_req_ready = 1'b0;
      step();
      chk("noreq_busy", {31'd0, busy}, 32'd0);
      return;
    end
    ea  = exp_lsu ? la : ia;
    ew  = exp_lsu ? w : 1'b0;
    ewd = exp_lsu ? wd : 32'd0;
    ewm = exp_lsu ? wm : 4'd0;
    m_owner    = exp_lsu;
    m_last_lsu = exp_lsu;
    step();
    // ISSUE: fields stay put while requesters wander and stray responses arrive
    for (int k = 0; k <= rdly; k++) begin
      chk("issue_valid", {31'd0, mem_req_valid}, 32'd1);
      chk("issue_addr", mem_addr, ea);
      chk("issue_wen", {31'd0, mem_wen}, {31'd0, ew});
      chk("issue_wdata", mem_wdata, ewd);
      chk("issue_wmask", {28'd0, mem_wmask}, {28'd0, ewm});
      chk("issue_busy", {31'd0, busy}, 32'd1);
      chk("issue_owner", {31'd0, owner}, {31'd0, m_owner});
      chk("issue_resp", {30'd0, ifu_resp_valid, lsu_resp_valid}, 32'd0);
      ifu_req_valid  = 1'($urandom);
      lsu_req_valid  = 1'($urandom);
      ifu_addr       = ifu_addr + 32'd4;
      lsu_addr       = $urandom;
      lsu_wen        = 1'($urandom);
      lsu_wdata      = $urandom;
      lsu_wmask      = 4'($urandom);
      mem_resp_valid = 1'($urandom);
      mem_rdata      = $urandom;
      mem_req_ready  = (k == rdly);
      #1;
      chk("issue_ready", {30'd0, ifu_req_ready, lsu_req_ready}, 32'd0);
      step();
    end
    // WAIT: no request visible, mem_req_ready ignored
    for (int k = 0; k <= pdly; k++) begin
      chk("wait_valid", {31'd0, mem_req_valid}, 32'd0);
      chk("wait_busy", {31'd0, busy}, 32'd1);
      chk("wait_resp", {30'd0, ifu_resp_valid, lsu_resp_valid}, 32'd0);
      ifu_req_valid  = 1'($urandom);
      lsu_req_valid  = 1'($urandom);
      mem_req_ready  = 1'($urandom);
      mem_resp_valid = (k == pdly);
      mem_rdata      = (k == pdly) ? rd : $urandom;
      #1;
      chk("wait_ready", {30'd0, ifu_req_ready, lsu_req_ready}, 32'd0);
      step();
    end
    if (m_owner) m_lsu_rdata = rd;
    else         m_ifu_rdata = rd;
    chk("resp_ifu_valid", {31'd0, ifu_resp_valid}, {31'd0, !m_owner});
    chk("resp_lsu_valid", {31'd0, lsu_resp_valid}, {31'd0, m_owner});
    chk("resp_ifu_rdata", ifu_rdata, m_ifu_rdata);
    chk("resp_lsu_rdata", lsu_rdata, m_lsu_rdata);
    chk("resp_busy", {31'd0, busy}, 32'd0);
    chk("resp_mem_valid", {31'd0, mem_req_valid}, 32'd0);
    ifu_req_valid  = 1'b0;
    lsu_req_valid  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_req_ready  = 1'b0;
  endtask

  logic        tie_exp [3];
  logic        r_iv;
  logic        r_lv;

  initial begin
    n_asserts      = 0;
    n_fails        = 0;
    rst_n          = 1'b0;
    ifu_req_valid  = 1'b0;
    ifu_addr       = 32'd0;
    lsu_req_valid  = 1'b0;
    lsu_addr       = 32'd0;
    lsu_wen        = 1'b0;
    lsu_wdata      = 32'd0;
    lsu_wmask      = 4'd0;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_rdata      = 32'd0;
    model_reset();
    #2;
    // reset state
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_owner", {31'd0, owner}, 32'd0);
    chk("rst_mem_valid", {31'd0, mem_req_valid}, 32'd0);
    chk("rst_resp", {30'd0, ifu_resp_valid, lsu_resp_valid}, 32'd0);
    chk("rst_ifu_rdata", ifu_rdata, 32'd0);
    chk("rst_lsu_rdata", lsu_rdata, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    step();
    step();
    rst_n = 1'b1;
    step();

    // IFU-only read, zero-wait memory: response visible three cycles after accept
    txn(1'b1, 1'b0, 32'h8000_0000, 32'd0, 1'b0, 32'd0, 4'd0, 0, 0, 32'h0000_0413);
    chk("ifu_read_data", ifu_rdata, 32'h0000_0413);
    chk("ifu_read_lsu_quiet", {31'd0, lsu_resp_valid}, 32'd0);
    step();
    chk("ifu_read_pulse_end", {31'd0, ifu_resp_valid}, 32'd0);
    chk("ifu_read_data_hold", ifu_rdata, 32'h0000_0413);

    // LSU write held off by the memory for three cycles
    txn(1'b0, 1'b1, 32'd0, 32'h8000_0100, 1'b1, 32'hDEAD_BEEF, 4'hF, 3, 1, 32'h1234_5678);
    step();

    // IFU address changes during ISSUE must not reach mem_addr
    txn(1'b1, 1'b0, 32'h8000_0000, 32'd0, 1'b0, 32'd0, 4'd0, 2, 0, 32'hCAFE_0001);
    step();

    // stray response in IDLE is ignored
    mem_resp_valid = 1'b1;
    mem_rdata      = 32'hBAD0_BAD0;
    step();
    mem_resp_valid = 1'b0;
    chk("stray_busy", {31'd0, busy}, 32'd0);
    chk("stray_resp", {30'd0, ifu_resp_valid, lsu_resp_valid}, 32'd0);
    chk("stray_ifu_rdata", ifu_rdata, m_ifu_rdata);
    chk("stray_lsu_rdata", lsu_rdata, m_lsu_rdata);
    step();
    chk("stray_resp_later", {30'd0, ifu_resp_valid, lsu_resp_valid}, 32'd0);

    // reset while waiting on the memory abandons the transaction
    ifu_req_valid = 1'b1;
    ifu_addr      = 32'h8000_0040;
    step();
    ifu_req_valid = 1'b0;
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    chk("pre_rst_wait_busy", {31'd0, busy}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("async_rst_busy", {31'd0, busy}, 32'd0);
    chk("async_rst_owner", {31'd0, owner}, 32'd0);
    chk("async_rst_ifu_rdata", ifu_rdata, 32'd0);
    chk("async_rst_lsu_rdata", lsu_rdata, 32'd0);
    step();
    rst_n          = 1'b1;
    mem_resp_valid = 1'b1;
    mem_rdata      = 32'h5555_AAAA;
    step();
    mem_resp_valid = 1'b0;
    chk("late_resp_busy", {31'd0, busy}, 32'd0);
    chk("late_resp_none", {30'd0, ifu_resp_valid, lsu_resp_valid}, 32'd0);
    step();
    chk("late_resp_none2", {30'd0, ifu_resp_valid, lsu_resp_valid}, 32'd0);
    chk("late_resp_rdata", ifu_rdata, 32'd0);

    // three back-to-back ties straight after reset
`ifdef ARB_RR_EN
    tie_exp[0] = 1'b1; tie_exp[1] = 1'b0; tie_exp[2] = 1'b1;
`else
    tie_exp[0] = 1'b1; tie_exp[1] = 1'b1; tie_exp[2] = 1'b1;
`endif
    for (int t = 0; t < 3; t++) begin
      txn(1'b1, 1'b1, 32'h8000_1000 + 32'(t), 32'h8000_2000 + 32'(t), 1'b0, 32'd0, 4'd0,
          0, 0, 32'hA000_0000 + 32'(t));
      chk("tie_owner", {31'd0, owner}, {31'd0, tie_exp[t]});
    end
    step();

    // randomized traffic, including idle gaps and ties
    for (int i = 0; i < 60; i++) begin
      r_iv = 1'($urandom);
      r_lv = 1'($urandom);
      txn(r_iv, r_lv, $urandom, $urandom, 1'($urandom), $urandom, 4'($urandom),
          int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), $urandom);
      if ($urandom_range(0, 3) == 0) step();
    end
    step();
    chk("final_resp_clear", {30'd0, ifu_resp_valid, lsu_resp_valid}, 32'd0);
    chk("final_busy", {31'd0, busy}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule
